// File: rtl/clk_enable_gen_pkg.sv
// Shared types and default sizing for the clock-enable generator.
package clk_enable_gen_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_LOCK = 2'd1,
      ALIGN     = 2'd2,
      RUN       = 2'd3
   } state_t;

   localparam int DEFAULT_NUM_CH      = 4;
   localparam int DEFAULT_DIV_W       = 8;
   localparam int DEFAULT_LOCK_CYCLES = 1024;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/clk_enable_gen.sv
// Phase-aligned clock-enable generator: waits for a debounced PLL lock, then
// emits one-cycle cen pulses of period div+1 per channel.
module clk_enable_gen
   import clk_enable_gen_pkg::*;
#(
   parameter int NUM_CH      = DEFAULT_NUM_CH,
   parameter int DIV_W       = DEFAULT_DIV_W,
   parameter int LOCK_CYCLES = DEFAULT_LOCK_CYCLES
) (
   input  logic                    refclk,
   input  logic                    rst_n,
   input  logic                    pll_locked,
   input  logic                    run,
   input  logic [NUM_CH*DIV_W-1:0] div,
   input  logic [NUM_CH*DIV_W-1:0] phase,
   output logic [NUM_CH-1:0]       cen,
   output logic                    ready
);

   // The debounce counter is sized from LOCK_CYCLES, which can exceed the DIV_W range.
   localparam int                LOCK_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

   state_t            state;
   logic              lock_s;
   logic [LOCK_W-1:0] lock_cnt;
   logic              run_hold;
   logic              load_ch;

   sync_2ff u_lock_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (lock_s)
   );

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ready    <= 1'b0;
         lock_cnt <= '0;
      end else begin
         ready <= 1'b0;
         if (!run) begin
            state    <= IDLE;
            lock_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  state    <= WAIT_LOCK;
                  lock_cnt <= '0;
               end
               WAIT_LOCK: begin
                  if (!lock_s) begin
                     lock_cnt <= '0;
                  end else if (lock_cnt == LOCK_LAST) begin
                     state    <= ALIGN;
                     lock_cnt <= '0;
                  end else begin
                     lock_cnt <= lock_cnt + LOCK_W'(1);
                  end
               end
               ALIGN: begin
                  lock_cnt <= '0;
                  if (!lock_s) begin
                     state <= WAIT_LOCK;
                  end else begin
                     state <= RUN;
                     ready <= 1'b1;
                  end
               end
               RUN: begin
                  lock_cnt <= '0;
                  if (!lock_s) begin
                     state <= WAIT_LOCK;
                  end else begin
                     ready <= 1'b1;
                  end
               end
               default: begin
                  state    <= IDLE;
                  lock_cnt <= '0;
               end
            endcase
         end
      end
   end

   // Channels only count while RUN persists into the next cycle, so cen drops with ready.
   assign run_hold = run && lock_s && (state == RUN);
   assign load_ch  = (state == ALIGN);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [DIV_W-1:0] div_i;
      logic [DIV_W-1:0] phase_i;
      logic [DIV_W-1:0] cnt;
      logic [DIV_W-1:0] div_act;
      logic             cen_q;

      assign div_i   = div[i*DIV_W +: DIV_W];
      assign phase_i = phase[i*DIV_W +: DIV_W];
      assign cen[i]  = cen_q;

      // div is only sampled at ALIGN or a terminal count so periods are never cut short.
      always_ff @(posedge refclk or negedge rst_n) begin
         if (!rst_n) begin
            cnt     <= '0;
            div_act <= '0;
            cen_q   <= 1'b0;
         end else if (load_ch) begin
            div_act <= div_i;
            cnt     <= (phase_i < div_i) ? phase_i : div_i;
            cen_q   <= 1'b0;
         end else if (run_hold) begin
            if (cnt == div_act) begin
               cnt     <= '0;
               cen_q   <= 1'b1;
               div_act <= div_i;
            end else begin
               cnt   <= cnt + DIV_W'(1);
               cen_q <= 1'b0;
            end
         end else begin
            cen_q <= 1'b0;
         end
      end
   end

endmodule
